// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: pipeline-side request/status (master) and the
// hazard scoreboard that answers with stall and multi-cycle status (slave).
interface hazard_scoreboard_if;
    localparam int unsigned REG_W = 5;
    localparam int unsigned NREG  = 32;

    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_is_multi;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             flush;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             mc_busy;
    logic             mc_done;
    logic [REG_W-1:0] mc_rd;
    logic [NREG-1:0]  sb_pending;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
               id_reg_write, id_is_multi, ex_mem_read, ex_rd, flush,
        input  pc_write, if_id_write, id_ex_bubble, mc_busy, mc_done, mc_rd,
               sb_pending
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
               id_reg_write, id_is_multi, ex_mem_read, ex_rd, flush,
        output pc_write, if_id_write, id_ex_bubble, mc_busy, mc_done, mc_rd,
               sb_pending
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard controller: load-use, multi-cycle RAW/structural stalls and
// a per-register pending-write scoreboard. Define HAZARD_WAW_CHECK_EN to add WAW stalls.
module hazard_scoreboard #(
    parameter int unsigned MC_LAT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  hz
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned REG_W = 5;
    localparam int unsigned NREG  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mc_state_e;

    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REG_W-1:0] mc_rd_q, mc_rd_d;
    logic [NREG-1:0]  sb_q, sb_d;

    logic live;
    logic load_use;
    logic raw_pending;
    logic structural;
    logic waw;
    logic stall;
    logic issue;

    // Hazard terms; a flushed ID instruction never stalls and never issues
    always_comb begin
        live        = hz.id_valid && !hz.flush;
        load_use    = hz.ex_mem_read && (hz.ex_rd != '0) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));
        raw_pending = (hz.id_uses_rs1 && sb_q[hz.id_rs1]) ||
                      (hz.id_uses_rs2 && sb_q[hz.id_rs2]);
        structural  = hz.id_is_multi && (state_q == RUN);
`ifdef HAZARD_WAW_CHECK_EN
        waw         = hz.id_reg_write && sb_q[hz.id_rd];
`else
        waw         = 1'b0;
`endif
        stall       = live && (load_use || raw_pending || structural || waw);
        issue       = live && hz.id_is_multi && !stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mc_rd_q <= '0;
            sb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mc_rd_q <= mc_rd_d;
            sb_q    <= sb_d;
        end
    end

    // Sequencer: issue only from IDLE (structural stall blocks it in RUN, including the done cycle)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_rd_d = mc_rd_q;
        sb_d    = sb_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = RUN;
                    cnt_d   = CNT_W'(MC_LAT);
                    mc_rd_d = hz.id_rd;
                    if (hz.id_reg_write && (hz.id_rd != '0)) begin
                        sb_d[hz.id_rd] = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d       = IDLE;
                    sb_d[mc_rd_q] = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign hz.pc_write     = !stall;
    assign hz.if_id_write  = !stall;
    assign hz.id_ex_bubble = stall;
    assign hz.mc_busy      = (state_q == RUN);
    assign hz.mc_done      = (state_q == RUN) && (cnt_q == CNT_W'(1));
    assign hz.mc_rd        = mc_rd_q;
    assign hz.sb_pending   = sb_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with MC_LAT=4;
// WAW expectations follow HAZARD_WAW_CHECK_EN.
module tb_hazard_scoreboard;
`ifdef HAZARD_WAW_CHECK_EN
    localparam bit WAW_EN = 1'b1;
`else
    localparam bit WAW_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if hz ();

    hazard_scoreboard #(.MC_LAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp_stall);
        chk({tag, "_pc_write"}, 32'(hz.pc_write), 32'(!exp_stall));
        chk({tag, "_if_id_write"}, 32'(hz.if_id_write), 32'(!exp_stall));
        chk({tag, "_bubble"}, 32'(hz.id_ex_bubble), 32'(exp_stall));
    endtask

    task automatic clr();
        hz.id_valid     = 1'b0;
        hz.id_rs1       = '0;
        hz.id_rs2       = '0;
        hz.id_uses_rs1  = 1'b0;
        hz.id_uses_rs2  = 1'b0;
        hz.id_rd        = '0;
        hz.id_reg_write = 1'b0;
        hz.id_is_multi  = 1'b0;
        hz.ex_mem_read  = 1'b0;
        hz.ex_rd        = '0;
        hz.flush        = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mul(input logic [4:0] rd);
        clr();
        hz.id_valid     = 1'b1;
        hz.id_is_multi  = 1'b1;
        hz.id_reg_write = 1'b1;
        hz.id_rd        = rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        clr();
        #2;
        chk_stall("reset", 1'b0);
        chk("reset_busy", 32'(hz.mc_busy), 32'd0);
        chk("reset_done", 32'(hz.mc_done), 32'd0);
        chk("reset_mc_rd", 32'(hz.mc_rd), 32'd0);
        chk("reset_sb", hz.sb_pending, 32'd0);
        next();
        rst_n = 1'b1;

        // Load-use
        next();
        clr();
        hz.id_valid = 1'b1; hz.id_rs1 = 5'd5; hz.id_uses_rs1 = 1'b1;
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5;
        #1 chk_stall("lu", 1'b1);
        next();
        hz.ex_mem_read = 1'b0; hz.ex_rd = 5'd0;
        #1 chk_stall("lu_after_bubble", 1'b0);
        next();
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0;
        #1 chk_stall("lu_x0", 1'b0);
        next();
        hz.ex_rd = 5'd6; hz.id_rs1 = 5'd1; hz.id_rs2 = 5'd6; hz.id_uses_rs2 = 1'b0;
        #1 chk_stall("lu_rs2_unused", 1'b0);
        hz.id_uses_rs2 = 1'b1;
        #1 chk_stall("lu_rs2", 1'b1);
        hz.flush = 1'b1;
        #1 chk_stall("lu_flush", 1'b0);

        // RAW on pending multi-cycle write
        next();
        mul(5'd7);
        #1 chk_stall("raw_issue", 1'b0);
        for (int k = 1; k <= 4; k++) begin
            next();
            clr();
            hz.id_valid = 1'b1; hz.id_rs2 = 5'd7; hz.id_uses_rs2 = 1'b1;
            #1;
            chk_stall("raw_wait", 1'b1);
            chk("raw_busy", 32'(hz.mc_busy), 32'd1);
            chk("raw_done", 32'(hz.mc_done), 32'(k == 4));
            chk("raw_sb7", 32'(hz.sb_pending[7]), 32'd1);
            chk("raw_mc_rd", 32'(hz.mc_rd), 32'd7);
        end
        next();
        #1;
        chk("raw_sb_clear", hz.sb_pending, 32'd0);
        chk_stall("raw_proceed", 1'b0);
        chk("raw_idle_busy", 32'(hz.mc_busy), 32'd0);
        chk("raw_idle_done", 32'(hz.mc_done), 32'd0);

        // Structural stall, then flush while second op in flight
        next();
        mul(5'd7);
        #1 chk_stall("st_issue", 1'b0);
        for (int k = 1; k <= 4; k++) begin
            next();
            mul(5'd9);
            #1;
            chk_stall("st_wait", 1'b1);
            chk("st_mc_rd_old", 32'(hz.mc_rd), 32'd7);
        end
        next();
        mul(5'd9);
        #1;
        chk_stall("st_issue2", 1'b0);
        chk("st_busy_idle", 32'(hz.mc_busy), 32'd0);
        next();
        mul(5'd3);
        hz.flush = 1'b1;
        #1;
        chk("st_mc_rd_new", 32'(hz.mc_rd), 32'd9);
        chk("st_busy", 32'(hz.mc_busy), 32'd1);
        chk("st_sb9", hz.sb_pending, 32'h0000_0200);
        chk_stall("fl_stall", 1'b0);
        for (int k = 0; k < 2; k++) begin
            next();
            clr();
            #1 chk("fl_no_done_yet", 32'(hz.mc_done), 32'd0);
        end
        next();
        #1;
        chk("fl_done", 32'(hz.mc_done), 32'd1);
        chk("fl_mc_rd", 32'(hz.mc_rd), 32'd9);
        next();
        #1;
        chk("fl_busy_end", 32'(hz.mc_busy), 32'd0);
        chk("fl_sb_end", hz.sb_pending, 32'd0);

        // Flush of a multi-cycle op while idle: no issue
        next();
        mul(5'd3);
        hz.flush = 1'b1;
        #1 chk_stall("fl_idle", 1'b0);
        next();
        clr();
        #1;
        chk("fl_idle_busy", 32'(hz.mc_busy), 32'd0);
        chk("fl_idle_sb", hz.sb_pending, 32'd0);

        // Multi-cycle op writing x0: never marked pending
        next();
        mul(5'd0);
        #1;
        next();
        clr();
        hz.id_valid = 1'b1; hz.id_uses_rs1 = 1'b1; hz.id_rs1 = 5'd0;
        #1;
        chk("x0_busy", 32'(hz.mc_busy), 32'd1);
        chk("x0_sb", hz.sb_pending, 32'd0);
        chk_stall("x0_src", 1'b0);
        for (int k = 0; k < 3; k++) next();
        next();
        #1 chk("x0_busy_end", 32'(hz.mc_busy), 32'd0);

        // WAW against pending register 7
        next();
        mul(5'd7);
        #1;
        for (int k = 1; k <= 4; k++) begin
            next();
            clr();
            hz.id_valid = 1'b1; hz.id_reg_write = 1'b1; hz.id_rd = 5'd7;
            #1 chk_stall("waw", WAW_EN);
        end
        next();
        #1;
        chk_stall("waw_clear", 1'b0);
        chk("waw_sb", hz.sb_pending, 32'd0);

        // Reset in the middle of an op
        next();
        mul(5'd12);
        #1;
        next();
        clr();
        #1;
        chk("rst_busy_pre", 32'(hz.mc_busy), 32'd1);
        chk("rst_sb_pre", hz.sb_pending, 32'h0000_1000);
        next();
        rst_n = 1'b0;
        #1;
        chk("rst_sb", hz.sb_pending, 32'd0);
        chk("rst_busy", 32'(hz.mc_busy), 32'd0);
        chk("rst_done", 32'(hz.mc_done), 32'd0);
        chk("rst_mc_rd", 32'(hz.mc_rd), 32'd0);
        next();
        next();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            next();
            #1;
            chk("rst_no_done", 32'(hz.mc_done), 32'd0);
            chk("rst_no_busy", 32'(hz.mc_busy), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Issue-side hazard controller for the 5-stage RISC-V pipeline, sitting at the ID stage. The forwarding unit handles results that can be bypassed into EX. This block handles the cases forwarding cannot cover. It stalls on load-use, tracks in-flight writes from the multi-cycle (mul/div) unit in a per-register scoreboard, sequences that unit's latency, and drives the pipeline stall and bubble controls.

## Interface
Parameters:
- `MC_LAT`, default 4: cycles from multi-cycle issue to `mc_done`. Legal range is 2..15.

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `id_valid`  in  1  ID holds a valid instruction
- `id_rs1`, `id_rs2`  in  5  ID source registers
- `id_uses_rs1`, `id_uses_rs2`  in  1  the corresponding source is actually read
- `id_rd`  in  5  ID destination register
- `id_reg_write`  in  1  ID instruction writes `id_rd`
- `id_is_multi`  in  1  ID instruction is a multi-cycle op
- `ex_mem_read`  in  1  the instruction in EX (ID/EX register) is a load
- `ex_rd`  in  5  EX destination register
- `flush`  in  1  branch taken; the ID instruction is killed this cycle
- `pc_write`  out  1  PC may advance
- `if_id_write`  out  1  IF/ID register may load
- `id_ex_bubble`  out  1  insert a NOP into ID/EX
- `mc_busy`  out  1  the multi-cycle unit is occupied
- `mc_done`  out  1  one-cycle pulse: the multi-cycle result writes back this cycle
- `mc_rd`  out  5  destination of the in-flight multi-cycle op
- `sb_pending`  out  32  scoreboard; bit r set means register r has a pending multi-cycle write

## Operation
Stall conditions. Each applies only when `id_valid && !flush`:
- **load_use**: `ex_mem_read && ex_rd!=0`, and either (`id_uses_rs1 && id_rs1==ex_rd`) or (`id_uses_rs2 && id_rs2==ex_rd`).
- **raw_pending**: (`id_uses_rs1 && sb_pending[id_rs1]`) or (`id_uses_rs2 && sb_pending[id_rs2]`).
- **structural**: `id_is_multi && mc_busy`.
- **waw**: `id_reg_write && sb_pending[id_rd]`. This condition exists only when the macro is defined (see Configuration).
- `stall` is the OR of all enabled conditions.

Output equations:
- `pc_write = if_id_write = !stall`.
- `id_ex_bubble = stall`.

Issue and scoreboard:
- Issue happens when `id_valid && id_is_multi && !stall && !flush`. On issue:
  - load the counter with `MC_LAT`;
  - capture `mc_rd <= id_rd`;
  - set `sb_pending[id_rd]` if `id_reg_write && id_rd!=0`.
- Bit 0 of the scoreboard is never set.

Multi-cycle sequencer (two states):
- **IDLE** (counter==0): `mc_busy=0`.
- **RUN** (counter>0): `mc_busy=1`. The counter decrements every cycle.
- `mc_done = (counter==1)`.
- On the edge that ends the done cycle, the counter reaches 0 and `sb_pending[mc_rd]` clears.

Other rules:
- `flush` kills only the ID instruction. An already-issued multi-cycle op always completes and clears its bit.
- The counter width is 4 bits. It never underflows and holds at 0.

## Timing
- Reset (async assert, sync-safe deassert):
  - `sb_pending=0`, counter=0, `mc_rd=0`;
  - `pc_write=1`, `if_id_write=1`, `id_ex_bubble=0`, `mc_busy=0`, `mc_done=0`.
  - Reset in the middle of an op abandons it; no `mc_done` follows.
- Stall outputs are combinational, valid within the same cycle as their inputs.
- Issue in cycle T gives:
  - `mc_busy` high in cycles T+1..T+MC_LAT;
  - `mc_done` high only in cycle T+MC_LAT;
  - scoreboard bit set in T+1..T+MC_LAT and clear from T+MC_LAT+1.
- A dependent instruction stalls through T+MC_LAT and proceeds in T+MC_LAT+1. The register file is write-first, so no bypass is needed.
- The next multi-cycle op issues at T+MC_LAT+1 at the earliest. The structural stall covers the done cycle.
- A load-use stall lasts exactly 1 cycle, because the bubble removes the load dependency.
- If `flush` and `stall` are both asserted, `flush` wins: `stall=0` and no issue occurs.
- Sources equal to x0 never stall.

## Configuration
- `HAZARD_WAW_CHECK_EN` defined:
  - the waw condition is included in `stall`;
  - an instruction writing a register with a pending multi-cycle write waits until that bit clears.
- Undefined:
  - there is no waw term;
  - the scoreboard is still maintained;
  - an ALU write to a pending register may be overwritten later by `mc_done`. Software or the compiler must avoid this case.

## Test plan
- **Load-use stall.** EX holds a load with `ex_rd=5`, `ex_mem_read=1`; ID has `id_rs1=5`, `id_uses_rs1=1`. Expect `pc_write=0`, `id_ex_bubble=1` for one cycle. With `ex_rd=0`, expect no stall.
- **RAW on a pending write.** With `MC_LAT=4`, issue a mul with `id_rd=7` at T, then present `id_rs2=7` from T+1. Expect stall in T+1..T+4, `mc_done` only in T+4, `sb_pending[7]` clear at T+5 and no stall at T+5.
- **Structural stall.** Issue a second mul at T+1. Expect stall through T+4 and issue at T+5, with `mc_rd` updated to the new rd at T+6.
- **Flush.** Assert `flush` alongside a stalling multi-cycle op in ID. Expect `stall=0`, no issue and the counter unchanged. An already-in-flight op still pulses `mc_done`.
- **WAW check.** With `HAZARD_WAW_CHECK_EN`, an ALU op with `id_rd=7` while bit 7 is pending stalls until the bit clears. Without the macro, there is no stall.
- **Reset mid-op.** Assert `rst_n=0` at T+2. Expect `sb_pending=0`, `mc_busy=0` and no `mc_done` afterwards.
